clkgen_lock: RTL and testbench

- Synthesizable, parametrised successor to the fixed two-output PLL stand-in.
- Generates NCH clock-enable pulse trains and matching square-wave strobes from one system clock, each with its own runtime divide ratio and phase offset.
- Output gating and a `locked` flag follow a lock-acquisition state machine, replacing the fixed simulation delay.
- Sits at the top of the SoC clocking tree. Downstream logic stays on clk and uses `ce[i]` as its clock enable.

---
 rtl/clkgen_pkg.sv | 31 +++
 rtl/clkgen_chan.sv | 78 +++++++
 rtl/clkgen_lock.sv | 169 ++++++++++++++++
 tb/tb_clkgen_lock.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
//   Shared definitions for the clkgen_lock clock-enable generator:
//   - state_t     : lock-acquisition FSM states (OFF, ACQUIRE, LOCKED)
//   - *_DEF       : default parameter values for NCH, DIV_W and LOCK_CYCLES
//   - eff_div     : clamps a divide ratio of 0 up to 1
//   - eff_phase   : clamps a phase offset to (effective divide - 1)
//   The helpers work on 32-bit values; callers cast to their field width.
// ---------------------------------------------------------------------------
package clkgen_pkg;

    localparam int NCH_DEF         = 2;
    localparam int DIV_W_DEF       = 8;
    localparam int LOCK_CYCLES_DEF = 180;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    // d must already be an effective (non-zero) divide.
    function automatic logic [31:0] eff_phase(input logic [31:0] p, input logic [31:0] d);
        return (p > d - 32'd1) ? d - 32'd1 : p;
    endfunction

endpackage

// File: rtl/clkgen_chan.sv
// ---------------------------------------------------------------------------
// clkgen_chan
//   One output channel: shadow divide register, 0..d-1 wrap counter and the
//   registered ce / sq generation.
//   Ports:
//     clk, rst_n  : system clock, asynchronous active-low reset
//     load        : lock-entry edge; sample div/phase, counter <= phase
//     run         : stay LOCKED; counter advances and wraps
//     div, phase  : raw divide / phase fields for this channel
//     ce          : one-cycle pulse when the counter holds d-1
//     sq          : high while the counter is below ceil(d/2)
//   With neither load nor run the counter and outputs are forced to 0.
// ---------------------------------------------------------------------------
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    output logic             ce,
    output logic             sq
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    // The phase is only needed on the load edge (it becomes the counter's
    // first value), so only the effective divide is kept as a shadow copy.
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] phase_eff;
    logic [DIV_W-1:0] d_use;
    logic [DIV_W-1:0] last;
    logic [DIV_W-1:0] half;
    logic             active;

    always_comb begin
        div_eff   = DIV_W'(eff_div(32'(div)));
        phase_eff = DIV_W'(eff_phase(32'(phase), 32'(div_eff)));
        // On the load edge the freshly sampled divide applies immediately.
        d_use     = load ? div_eff : div_reg;
        last      = d_use - ONE;
        half      = (d_use >> 1) + DIV_W'(d_use[0]);   // ceil(d/2)
        active    = load | run;
        if (load) begin
            cnt_next = phase_eff;
        end else if (run) begin
            cnt_next = (cnt_reg == last) ? '0 : cnt_reg + ONE;
        end else begin
            cnt_next = '0;
        end
    end

    // ce/sq are computed from the next counter value so the registered
    // outputs line up with the counter value held in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= ONE;
            cnt_reg <= '0;
            ce      <= 1'b0;
            sq      <= 1'b0;
        end else begin
            if (load) begin
                div_reg <= div_eff;
            end
            cnt_reg <= cnt_next;
            ce      <= active && (cnt_next == last);
            sq      <= active && (cnt_next < half);
        end
    end

endmodule

// File: rtl/clkgen_lock.sv
// ---------------------------------------------------------------------------
// clkgen_lock
//   NCH-channel clock-enable / square-wave generator gated by a lock
//   acquisition FSM (OFF -> ACQUIRE -> LOCKED).
//   Optional build macro: CLKGEN_LOCK_MON_EN adds the ref_ok input, a
//   LOSS_CYCLES loss-of-reference monitor and a sticky lock_lost flag.
//   Ports:
//     clk, rst_n  : system clock, asynchronous active-low reset
//     en          : level enable, 0 = powered down
//     relock      : single-cycle re-acquire request (re-samples div/phase)
//     div, phase  : per-channel fields, channel i at [i*DIV_W +: DIV_W]
//     ref_ok      : reference valid (monitor builds only)
//     ce, sq      : per-channel clock enable pulse and square wave
//     locked      : outputs are live
//     lock_lost   : sticky, lock broken by the monitor (0 without monitor)
// ---------------------------------------------------------------------------
module clkgen_lock
    import clkgen_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
`ifdef CLKGEN_LOCK_MON_EN
    ,
    parameter int LOSS_CYCLES = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 relock,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic [NCH*DIV_W-1:0] phase,
`ifdef CLKGEN_LOCK_MON_EN
    input  logic                 ref_ok,
`endif
    output logic [NCH-1:0]       ce,
    output logic [NCH-1:0]       sq,
    output logic                 locked,
    output logic                 lock_lost
);

    localparam int              LC_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
    localparam logic [LC_W-1:0] LC_ONE    = LC_W'(1);

    state_t          state_reg;
    state_t          state_next;
    logic [LC_W-1:0] lock_cnt_reg;
    logic [LC_W-1:0] lock_cnt_next;
    logic            load;
    logic            run;
    logic            ref_good;
    logic            loss_fire;

`ifdef CLKGEN_LOCK_MON_EN
    localparam int              LS_W      = $clog2(LOSS_CYCLES + 1);
    localparam logic [LS_W-1:0] LOSS_LAST = LS_W'(LOSS_CYCLES - 1);
    localparam logic [LS_W-1:0] LS_ONE    = LS_W'(1);

    logic [LS_W-1:0] loss_cnt_reg;
    logic [LS_W-1:0] loss_cnt_next;
    logic            lock_lost_reg;

    always_comb begin
        ref_good      = ref_ok;
        // Fires on the edge that samples the LOSS_CYCLES-th consecutive low.
        loss_fire     = (state_reg == LOCKED) && en && !ref_ok && (loss_cnt_reg == LOSS_LAST);
        loss_cnt_next = '0;
        if (state_reg == LOCKED && en && !ref_ok && !loss_fire) begin
            loss_cnt_next = loss_cnt_reg + LS_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg  <= '0;
            lock_lost_reg <= 1'b0;
        end else begin
            loss_cnt_reg <= loss_cnt_next;
            if (loss_fire) begin
                lock_lost_reg <= 1'b1;
            end else if (state_reg == OFF && en) begin
                lock_lost_reg <= 1'b0;
            end
        end
    end

    assign lock_lost = lock_lost_reg;
`else
    assign ref_good  = 1'b1;
    assign loss_fire = 1'b0;
    assign lock_lost = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        load          = 1'b0;
        run           = 1'b0;
        case (state_reg)
            OFF: begin
                if (en) begin
                    state_next    = ACQUIRE;
                    lock_cnt_next = '0;
                end
            end
            ACQUIRE: begin
                if (!en) begin
                    state_next    = OFF;
                    lock_cnt_next = '0;
                end else if (relock || !ref_good) begin
                    // relock beats lock completion; a bad reference pins the count.
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == LOCK_LAST) begin
                    state_next = LOCKED;
                    load       = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt_reg + LC_ONE;
                end
            end
            LOCKED: begin
                if (!en) begin
                    state_next = OFF;
                end else if (relock || loss_fire) begin
                    state_next    = ACQUIRE;
                    lock_cnt_next = '0;
                end else begin
                    run = 1'b1;
                end
            end
            default: begin
                state_next    = OFF;
                lock_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= OFF;
            lock_cnt_reg <= '0;
            locked       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            locked       <= (state_next == LOCKED);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            clkgen_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load),
                .run   (run),
                .div   (div[gi*DIV_W +: DIV_W]),
                .phase (phase[gi*DIV_W +: DIV_W]),
                .ce    (ce[gi]),
                .sq    (sq[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clkgen_lock.sv
`timescale 1ns/1ps
module tb_clkgen_lock;

    localparam int NCH         = 2;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 180;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b0;
    logic                 en     = 1'b0;
    logic                 relock = 1'b0;
    logic [NCH*DIV_W-1:0] div    = '0;
    logic [NCH*DIV_W-1:0] phase  = '0;
`ifdef CLKGEN_LOCK_MON_EN
    logic                 ref_ok = 1'b1;
`endif
    logic [NCH-1:0]       ce;
    logic [NCH-1:0]       sq;
    logic                 locked;
    logic                 lock_lost;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard entries are {ce, sq} for one LOCKED cycle.
    logic [2*NCH-1:0] exp_q[$];

    always #5 clk = ~clk;

    clkgen_lock #(
        .NCH         (NCH),
        .DIV_W       (DIV_W),
`ifdef CLKGEN_LOCK_MON_EN
        .LOSS_CYCLES (4),
`endif
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .relock    (relock),
        .div       (div),
        .phase     (phase),
`ifdef CLKGEN_LOCK_MON_EN
        .ref_ok    (ref_ok),
`endif
        .ce        (ce),
        .sq        (sq),
        .locked    (locked),
        .lock_lost (lock_lost)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: predict n LOCKED cycles from the raw div/phase values.
    task automatic push_model(input int d0, input int p0, input int d1, input int p1, input int n);
        int d[NCH];
        int c[NCH];
        int p[NCH];
        logic [NCH-1:0] e_ce;
        logic [NCH-1:0] e_sq;
        d[0] = (d0 == 0) ? 1 : d0;
        d[1] = (d1 == 0) ? 1 : d1;
        p[0] = p0;
        p[1] = p1;
        for (int i = 0; i < NCH; i++) c[i] = (p[i] > d[i] - 1) ? d[i] - 1 : p[i];
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NCH; i++) begin
                e_ce[i] = (c[i] == d[i] - 1);
                e_sq[i] = (c[i] < (d[i] + 1) / 2);
                c[i]    = (c[i] == d[i] - 1) ? 0 : c[i] + 1;
            end
            exp_q.push_back({e_ce, e_sq});
        end
    endtask

    // Compare n consecutive LOCKED cycles against the scoreboard.
    task automatic check_run(input string name, input int n);
        logic [2*NCH-1:0] e;
        for (int k = 0; k < n; k++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s cycle %0d: scoreboard empty, got ce=%b sq=%b", name, k, ce, sq);
            end else begin
                e = exp_q.pop_front();
                if ({locked, ce, sq} !== {1'b1, e}) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: got locked=%b ce=%b sq=%b, expected locked=1 ce=%b sq=%b",
                             name, k, locked, ce, sq, e[2*NCH-1:NCH], e[NCH-1:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    // Count edges until locked rises; outputs must stay quiet meanwhile.
    task automatic wait_lock(input string name, input int exp_edges);
        int n = 0;
        bit noisy = 1'b0;
        do begin
            @(negedge clk);
            relock = 1'b0;
            n++;
            if (!locked && (ce != '0 || sq != '0)) noisy = 1'b1;
        end while (!locked && n < 400);
        vectors++;
        if (n !== exp_edges) begin
            miscompares++;
            $display("FAIL %s lock_edges: got %0d, expected %0d", name, n, exp_edges);
        end
        vectors++;
        if (noisy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s quiet_acquire: got activity=%b, expected 0", name, noisy);
        end
    endtask

    task automatic restart(input string name, input int d0, input int p0, input int d1, input int p1);
        exp_q.delete();
        en    = 1'b0;
        div   = {DIV_W'(d1), DIV_W'(d0)};
        phase = {DIV_W'(p1), DIV_W'(p0)};
        @(negedge clk);
        en = 1'b1;
        wait_lock(name, LOCK_CYCLES + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ce, sq, locked, lock_lost} !== '0) begin
            miscompares++;
            $display("FAIL reset: got ce=%b sq=%b locked=%b lock_lost=%b, expected all 0",
                     ce, sq, locked, lock_lost);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ce, sq, locked, lock_lost} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got ce=%b sq=%b locked=%b lock_lost=%b, expected all 0",
                     ce, sq, locked, lock_lost);
        end
    endtask

    task automatic test_basic();
        restart("basic", 4, 0, 3, 0);
        push_model(4, 0, 3, 0, 12);
        check_run("basic", 12);
    endtask

    task automatic test_div_min();
        restart("div0", 0, 0, 3, 0);
        push_model(0, 0, 3, 0, 6);
        check_run("div0", 6);
        restart("div1", 1, 0, 2, 1);
        push_model(1, 0, 2, 1, 6);
        check_run("div1", 6);
    endtask

    task automatic test_phase();
        restart("phase2", 4, 2, 3, 1);
        push_model(4, 2, 3, 1, 8);
        check_run("phase2", 8);
        restart("phase9", 4, 9, 5, 7);
        push_model(4, 9, 5, 7, 8);
        check_run("phase9", 8);
    endtask

    task automatic test_div_change();
        restart("divchg", 4, 0, 3, 0);
        push_model(4, 0, 3, 0, 12);
        check_run("divchg_pre", 4);
        div[DIV_W-1:0] = DIV_W'(6);
        check_run("divchg_held", 8);
        relock = 1'b1;
        wait_lock("divchg_relock", LOCK_CYCLES + 1);
        push_model(6, 0, 3, 0, 12);
        check_run("divchg_post", 12);
    endtask

    task automatic test_relock_last();
        exp_q.delete();
        en    = 1'b0;
        div   = {DIV_W'(5), DIV_W'(2)};
        phase = '0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= LOCK_CYCLES; k++) begin
            @(negedge clk);
            if (k == LOCK_CYCLES) relock = 1'b1;
        end
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL relock_last_prelock: got locked=%b, expected 0", locked);
        end
        wait_lock("relock_last", LOCK_CYCLES + 1);
        push_model(2, 0, 5, 0, 6);
        check_run("relock_last", 6);
    endtask

    task automatic test_disable();
        restart("disable", 1, 0, 1, 0);
        push_model(1, 0, 1, 0, 3);
        check_run("disable_pre", 3);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({locked, ce, sq} !== '0) begin
            miscompares++;
            $display("FAIL disable: got locked=%b ce=%b sq=%b, expected all 0", locked, ce, sq);
        end
    endtask

`ifdef CLKGEN_LOCK_MON_EN
    task automatic test_monitor();
        ref_ok = 1'b1;
        restart("mon", 4, 0, 3, 0);
        vectors++;
        if (lock_lost !== 1'b0) begin
            miscompares++;
            $display("FAIL mon_initial: got lock_lost=%b, expected 0", lock_lost);
        end
        ref_ok = 1'b0;
        repeat (3) @(negedge clk);
        ref_ok = 1'b1;
        @(negedge clk);
        vectors++;
        if ({locked, lock_lost} !== 2'b10) begin
            miscompares++;
            $display("FAIL mon_short_drop: got locked=%b lock_lost=%b, expected 1 0", locked, lock_lost);
        end
        ref_ok = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (k < 4 && locked !== 1'b1) begin
                miscompares++;
                $display("FAIL mon_drop_%0d: got locked=%b, expected 1", k, locked);
            end else if (k == 4 && {locked, lock_lost, ce, sq} !== {1'b0, 1'b1, {(2*NCH){1'b0}}}) begin
                miscompares++;
                $display("FAIL mon_loss: got locked=%b lock_lost=%b ce=%b sq=%b, expected 0 1 0 0",
                         locked, lock_lost, ce, sq);
            end
        end
        ref_ok = 1'b1;
        wait_lock("mon_reacquire", LOCK_CYCLES);
        vectors++;
        if (lock_lost !== 1'b1) begin
            miscompares++;
            $display("FAIL mon_sticky: got lock_lost=%b, expected 1", lock_lost);
        end
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (lock_lost !== 1'b1) begin
            miscompares++;
            $display("FAIL mon_sticky_off: got lock_lost=%b, expected 1", lock_lost);
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (lock_lost !== 1'b0) begin
            miscompares++;
            $display("FAIL mon_clear: got lock_lost=%b, expected 0", lock_lost);
        end
    endtask
`endif

    task automatic test_async_reset();
        restart("async_rst", 1, 0, 1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({locked, ce, sq, lock_lost} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got locked=%b ce=%b sq=%b lock_lost=%b, expected all 0",
                     locked, ce, sq, lock_lost);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_min();
        test_phase();
        test_div_change();
        test_relock_last();
        test_disable();
`ifdef CLKGEN_LOCK_MON_EN
        test_monitor();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
